ram_bist: RTL and testbench

RAM_BIST -- requirements
Module: ram_bist

---
 rtl/ram_bist.sv | 137 +++++++++++++
 tb/tb_ram_bist.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// ram_bist: three-phase BIST for an 8x16 RAM (write D, read D / write ~D, read ~D).
// Define RAM_BIST_ERRCNT_EN to add err_count and run every phase to completion instead of aborting.
module ram_bist #(
    parameter int ADDR_XOR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pattern,
    input  logic [15:0] mem_out,
    output logic [2:0]  mem_addr,
    output logic [15:0] mem_in,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        pass,
`ifdef RAM_BIST_ERRCNT_EN
    output logic [3:0]  err_count,
`endif
    output logic [2:0]  fail_addr
);

    typedef enum logic [2:0] {IDLE, W0, RW, R1, DONE} state_t;

    state_t      state;
    logic [15:0] seed;
    logic [2:0]  addr;
    logic [2:0]  addr_next;
    logic        last;
    logic [15:0] want;
    logic        mismatch;

`ifdef RAM_BIST_ERRCNT_EN
    localparam bit ABORT = 1'b0;
`else
    localparam bit ABORT = 1'b1;
`endif

    function automatic logic [15:0] base(input logic [15:0] s, input logic [2:0] a);
        return (ADDR_XOR != 0) ? (s ^ {13'b0, a}) : s;
    endfunction

    assign mem_addr  = addr;
    assign last      = (addr == 3'd7);
    assign addr_next = addr + 3'd1;

    // mem_out is combinational on mem_addr, so the compare sees the word before this cycle's write lands
    always_comb begin
        want     = (state == R1) ? ~base(seed, addr) : base(seed, addr);
        mismatch = ((state == RW) || (state == R1)) && (mem_out != want);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            seed      <= '0;
            addr      <= '0;
            mem_in    <= '0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= W0;
                        seed      <= pattern;
                        addr      <= '0;
                        mem_in    <= base(pattern, 3'd0);
                        mem_write <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b1;
                        fail_addr <= '0;
                    end
                end
                W0: begin
                    addr <= addr_next;
                    if (last) begin
                        state  <= RW;
                        mem_in <= ~base(seed, 3'd0);
                    end else begin
                        mem_in <= base(seed, addr_next);
                    end
                end
                RW, R1: begin
                    // pass doubles as the "no mismatch seen yet" flag so fail_addr keeps the first one
                    if (mismatch && pass) begin
                        fail_addr <= addr;
                        pass      <= 1'b0;
                    end
                    if ((mismatch && ABORT) || (state == R1 && last)) begin
                        state     <= DONE;
                        addr      <= '0;
                        mem_in    <= '0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (state == RW && last) begin
                        state     <= R1;
                        addr      <= '0;
                        mem_in    <= '0;
                        mem_write <= 1'b0;
                    end else if (state == RW) begin
                        addr   <= addr_next;
                        mem_in <= ~base(seed, addr_next);
                    end else begin
                        addr <= addr_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    addr      <= '0;
                    mem_in    <= '0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_BIST_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (start && (state == IDLE || state == DONE)) begin
            err_count <= '0;
        end else if (mismatch && err_count != 4'd15) begin
            err_count <= err_count + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Testbench for ram_bist: one instance with ADDR_XOR=1 and one with ADDR_XOR=0, each on its own
// behavioural 8x16 RAM whose reads pass through shared stuck-at-0 / stuck-at-1 bit masks.
`timescale 1ns/1ps
module tb_ram_bist;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      pattern;
    logic [1:0][15:0] mem_out;
    logic [1:0][15:0] mem_in;
    logic [1:0][2:0]  mem_addr;
    logic [1:0][2:0]  fail_addr;
    logic [1:0]       mem_write;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       pass;
`ifdef RAM_BIST_ERRCNT_EN
    logic [1:0][3:0]  err_count;
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif
    logic [7:0][15:0] stuck0;
    logic [7:0][15:0] stuck1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] ram [8];

        ram_bist #(.ADDR_XOR(g == 0 ? 1 : 0)) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .pattern   (pattern),
            .mem_out   (mem_out[g]),
            .mem_addr  (mem_addr[g]),
            .mem_in    (mem_in[g]),
            .mem_write (mem_write[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .pass      (pass[g]),
`ifdef RAM_BIST_ERRCNT_EN
            .err_count (err_count[g]),
`endif
            .fail_addr (fail_addr[g])
        );

        always_ff @(posedge clk) begin
            if (mem_write[g]) ram[mem_addr[g]] <= mem_in[g];
        end
        assign mem_out[g] = (ram[mem_addr[g]] & ~stuck0[mem_addr[g]]) | stuck1[mem_addr[g]];
    end

    // Reference expectations per instance (index 0 = ADDR_XOR=1, index 1 = ADDR_XOR=0)
    logic [15:0] cur_pattern;
    int          exp_n    [2];
    logic        exp_pass [2];
    logic [2:0]  exp_fail [2];
    int          exp_err  [2];
    logic [2:0]  exp_addr [2][24];
    logic        exp_wr   [2][24];
    logic [15:0] exp_data [2][24];
    int          meas_done [2];
    logic [15:0] cap_w0;
    logic [15:0] cap_rw;

    typedef struct packed {
        logic [15:0] pat;
        int          s0a;
        logic [15:0] s0m;
        int          s1a;
        logic [15:0] s1m;
        int          n0;
        logic        pass0;
        logic [2:0]  fail0;
        int          err0;
        int          n1;
        logic        pass1;
        logic [2:0]  fail1;
        int          err1;
        logic [15:0] w0_3;
        logic [15:0] rw_3;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Walks the three phases over an array-backed memory: write D, read D then write ~D, read ~D
    task automatic build_model(input int g);
        logic [15:0] mem [8];
        logic [15:0] d;
        logic [15:0] rd;
        logic [15:0] w;
        int          n = 0;
        int          errs = 0;
        bit          stop = 1'b0;
        exp_pass[g] = 1'b1;
        exp_fail[g] = 3'd0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int a = 0; a < 8; a++) begin
                if (!stop) begin
                    d = (g == 0) ? (cur_pattern ^ 16'(a)) : cur_pattern;
                    w = (ph == 0) ? d : ~d;
                    exp_addr[g][n] = 3'(a);
                    exp_wr[g][n]   = (ph < 2);
                    exp_data[g][n] = w;
                    if (ph > 0) begin
                        rd = (mem[a] & ~stuck0[a]) | stuck1[a];
                        if (rd != ((ph == 1) ? d : ~d)) begin
                            if (exp_pass[g]) exp_fail[g] = 3'(a);
                            exp_pass[g] = 1'b0;
                            if (errs < 15) errs++;
                            if (!ERRCNT) stop = 1'b1;
                        end
                    end
                    if (ph < 2) mem[a] = w;
                    n++;
                end
            end
        end
        exp_n[g]   = n;
        exp_err[g] = errs;
    endtask

    task automatic applyStimulus(input logic [15:0] p, input int a0, input logic [15:0] m0,
                                 input int a1, input logic [15:0] m1, input bit pulses);
        logic [1:0] was_done;
        stuck0 = '0;
        stuck1 = '0;
        stuck0[a0] = m0;
        stuck1[a1] = m1;
        cur_pattern = p;
        build_model(0);
        build_model(1);
        meas_done[0] = -1;
        meas_done[1] = -1;
        cap_w0 = '0;
        cap_rw = '0;
        was_done = done;
        pattern = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pattern = ~p;
        for (int c = 0; c < 26; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (c == 0 && was_done[g]) begin
                    checkOutput($sformatf("restart pass[%0d]", g), 32'(pass[g]), 1);
                    checkOutput($sformatf("restart fail_addr[%0d]", g), 32'(fail_addr[g]), 0);
`ifdef RAM_BIST_ERRCNT_EN
                    checkOutput($sformatf("restart err_count[%0d]", g), 32'(err_count[g]), 0);
`endif
                end
                if (done[g] && meas_done[g] < 0) meas_done[g] = c;
                if (c < exp_n[g]) begin
                    checkOutput($sformatf("busy[%0d] c%0d", g, c), 32'(busy[g]), 1);
                    checkOutput($sformatf("done[%0d] c%0d", g, c), 32'(done[g]), 0);
                    checkOutput($sformatf("mem_addr[%0d] c%0d", g, c), 32'(mem_addr[g]), 32'(exp_addr[g][c]));
                    checkOutput($sformatf("mem_write[%0d] c%0d", g, c), 32'(mem_write[g]), 32'(exp_wr[g][c]));
                    if (exp_wr[g][c])
                        checkOutput($sformatf("mem_in[%0d] c%0d", g, c), 32'(mem_in[g]), 32'(exp_data[g][c]));
                end else if (c == exp_n[g]) begin
                    checkOutput($sformatf("end busy[%0d]", g), 32'(busy[g]), 0);
                    checkOutput($sformatf("end done[%0d]", g), 32'(done[g]), 1);
                    checkOutput($sformatf("end mem_write[%0d]", g), 32'(mem_write[g]), 0);
                    checkOutput($sformatf("end mem_addr[%0d]", g), 32'(mem_addr[g]), 0);
                    checkOutput($sformatf("end mem_in[%0d]", g), 32'(mem_in[g]), 0);
                    checkOutput($sformatf("end pass[%0d]", g), 32'(pass[g]), 32'(exp_pass[g]));
                    checkOutput($sformatf("end fail_addr[%0d]", g), 32'(fail_addr[g]), 32'(exp_fail[g]));
`ifdef RAM_BIST_ERRCNT_EN
                    checkOutput($sformatf("end err_count[%0d]", g), 32'(err_count[g]), 32'(exp_err[g]));
`endif
                end
            end
            if (c == 3) cap_w0 = mem_in[0];
            if (c == 11) cap_rw = mem_in[0];
            if (pulses && (c == 4 || c == 19)) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        checkOutput("done latency[0]", 32'(meas_done[0]), 32'(exp_n[0]));
        checkOutput("done latency[1]", 32'(meas_done[1]), 32'(exp_n[1]));
    endtask

    initial begin
        vec_t        vecs [4];
        logic [15:0] rp;
        int          ra0;
        int          ra1;
        logic [15:0] rm0;
        logic [15:0] rm1;

        reset = 1'b1;
        start = 1'b0;
        pattern = '0;
        stuck0 = '0;
        stuck1 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("reset busy[%0d]", g), 32'(busy[g]), 0);
            checkOutput($sformatf("reset done[%0d]", g), 32'(done[g]), 0);
            checkOutput($sformatf("reset pass[%0d]", g), 32'(pass[g]), 0);
            checkOutput($sformatf("reset fail_addr[%0d]", g), 32'(fail_addr[g]), 0);
            checkOutput($sformatf("reset mem_write[%0d]", g), 32'(mem_write[g]), 0);
            checkOutput($sformatf("reset mem_addr[%0d]", g), 32'(mem_addr[g]), 0);
            checkOutput($sformatf("reset mem_in[%0d]", g), 32'(mem_in[g]), 0);
`ifdef RAM_BIST_ERRCNT_EN
            checkOutput($sformatf("reset err_count[%0d]", g), 32'(err_count[g]), 0);
`endif
        end
        reset = 1'b0;

        vecs[0] = '{16'hA5A0, 0, 16'h0000, 0, 16'h0000,
                    24, 1'b1, 3'd0, 0, 24, 1'b1, 3'd0, 0, 16'hA5A3, 16'h5A5C};
        vecs[1] = '{16'hA5A0, 5, 16'h0001, 0, 16'h0000,
                    ERRCNT ? 24 : 14, 1'b0, 3'd5, 1, ERRCNT ? 24 : 22, 1'b0, 3'd5, 1, 16'hA5A3, 16'h5A5C};
        vecs[2] = '{16'hFFFF, 5, 16'h0001, 2, 16'h0001,
                    ERRCNT ? 24 : 19, 1'b0, 3'd2, 2, ERRCNT ? 24 : 14, 1'b0, 3'd5, 2, 16'hFFFC, 16'h0003};
        vecs[3] = '{16'hFFFF, 0, 16'h0000, 0, 16'h0000,
                    24, 1'b1, 3'd0, 0, 24, 1'b1, 3'd0, 0, 16'hFFFC, 16'h0003};

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].pat, vecs[i].s0a, vecs[i].s0m, vecs[i].s1a, vecs[i].s1m, 1'b0);
            checkOutput($sformatf("vec%0d done cycle[0]", i), 32'(meas_done[0]), 32'(vecs[i].n0));
            checkOutput($sformatf("vec%0d done cycle[1]", i), 32'(meas_done[1]), 32'(vecs[i].n1));
            checkOutput($sformatf("vec%0d pass[0]", i), 32'(pass[0]), 32'(vecs[i].pass0));
            checkOutput($sformatf("vec%0d pass[1]", i), 32'(pass[1]), 32'(vecs[i].pass1));
            checkOutput($sformatf("vec%0d fail_addr[0]", i), 32'(fail_addr[0]), 32'(vecs[i].fail0));
            checkOutput($sformatf("vec%0d fail_addr[1]", i), 32'(fail_addr[1]), 32'(vecs[i].fail1));
            checkOutput($sformatf("vec%0d W0 addr3 mem_in", i), 32'(cap_w0), 32'(vecs[i].w0_3));
            checkOutput($sformatf("vec%0d RW addr3 mem_in", i), 32'(cap_rw), 32'(vecs[i].rw_3));
`ifdef RAM_BIST_ERRCNT_EN
            checkOutput($sformatf("vec%0d err_count[0]", i), 32'(err_count[0]), 32'(vecs[i].err0));
            checkOutput($sformatf("vec%0d err_count[1]", i), 32'(err_count[1]), 32'(vecs[i].err1));
`endif
        end

        // start pulses at k+5 and k+20 must not restart the run
        applyStimulus(16'hA5A0, 0, 16'h0000, 0, 16'h0000, 1'b1);
        checkOutput("busy-start done cycle", 32'(meas_done[0]), 24);

        // reset sampled at k+10 aborts the test
        pattern = 16'hA5A0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("midreset busy[%0d]", g), 32'(busy[g]), 0);
            checkOutput($sformatf("midreset done[%0d]", g), 32'(done[g]), 0);
            checkOutput($sformatf("midreset mem_write[%0d]", g), 32'(mem_write[g]), 0);
            checkOutput($sformatf("midreset mem_addr[%0d]", g), 32'(mem_addr[g]), 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("idle mem_write c%0d", c), 32'(mem_write), 0);
            checkOutput($sformatf("idle busy c%0d", c), 32'(busy), 0);
        end
        applyStimulus(16'hA5A0, 0, 16'h0000, 0, 16'h0000, 1'b0);

        // reset wins over start from DONE
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset-vs-start done", 32'(done), 0);
        checkOutput("reset-vs-start busy", 32'(busy), 0);
        @(posedge clk); #1;
        checkOutput("reset-vs-start stays idle", 32'(busy), 0);

        for (int r = 0; r < 6; r++) begin
            rp  = 16'($urandom);
            ra0 = int'($urandom_range(0, 7));
            ra1 = int'($urandom_range(0, 7));
            rm0 = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            rm1 = ($urandom_range(0, 1) == 1) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            applyStimulus(rp, ra0, rm0, ra1, rm1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
